data_store: RTL and testbench

- AXI4 write-initiator for the RV32I core's store path. It is the write-side counterpart of the instruction-fetch read path.
- Accepts store requests (address, data, byte enables) from the memory-access stage and buffers them in a small in-order FIFO.
- Drains each buffered request as a single-beat AXI write on the AW/W/B channels.
- Asserts MEM_WAIT to stall the pipeline when the buffer is full, and reports DRAINED so fences and loads can be ordered behind stores.

---
 rtl/data_store_pkg.sv | 37 +++
 rtl/data_store_if.sv | 62 ++++++
 rtl/data_store_store_fifo.sv | 71 +++++++
 rtl/data_store.sv | 184 ++++++++++++++++++
 tb/tb_data_store.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_store_pkg.sv
// -----------------------------------------------------------------------------
// data_store_pkg
//   Types and constants for the RV32I store path AXI write initiator.
//   - Fixed AXI attribute encodings (burst, size, cache, response codes)
//   - FSM state encoding shared by the top level
//   - Store-buffer entry layout {word address, byte enables, data}
// -----------------------------------------------------------------------------
package data_store_pkg;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [2:0] SIZE_4B      = 3'b010;
    localparam logic [3:0] CACHE_NORMAL = 4'b0011;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    // The low two address bits are never issued (AWADDR is word aligned),
    // so only the word address is buffered.
    typedef struct packed {
        logic [29:0] word_addr;
        logic [3:0]  be;
        logic [31:0] data;
    } store_entry_t;

    // SLVERR and DECERR both carry BRESP[1]=1.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/data_store_if.sv
// -----------------------------------------------------------------------------
// data_store_if
//   AXI4 write-channel bundle (AW, W, B) between the store initiator and the
//   memory system.
//   master : drives AW*/W*/BREADY, receives AWREADY/WREADY/B*
//   slave  : the opposite direction
// -----------------------------------------------------------------------------
interface data_store_if #(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int C_M_AXI_WUSER_WIDTH     = 4,
    parameter int C_M_AXI_BUSER_WIDTH     = 1
);
    // Write address channel
    logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID;
    logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR;
    logic [7:0]                         M_AXI_AWLEN;
    logic [2:0]                         M_AXI_AWSIZE;
    logic [1:0]                         M_AXI_AWBURST;
    logic [1:0]                         M_AXI_AWLOCK;
    logic [3:0]                         M_AXI_AWCACHE;
    logic [2:0]                         M_AXI_AWPROT;
    logic [3:0]                         M_AXI_AWQOS;
    logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER;
    logic                               M_AXI_AWVALID;
    logic                               M_AXI_AWREADY;
    // Write data channel
    logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB;
    logic                               M_AXI_WLAST;
    logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER;
    logic                               M_AXI_WVALID;
    logic                               M_AXI_WREADY;
    // Write response channel
    logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID;
    logic [1:0]                         M_AXI_BRESP;
    logic [C_M_AXI_BUSER_WIDTH-1:0]     M_AXI_BUSER;
    logic                               M_AXI_BVALID;
    logic                               M_AXI_BREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
               M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
               M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY,
               M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
               M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
               M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY,
               M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID
    );
endinterface

// File: rtl/data_store_store_fifo.sv
// -----------------------------------------------------------------------------
// store_fifo
//   In-order synchronous store buffer, 2^DEPTH_LOG2 entries.
//   CLK, RST    : clock, asynchronous active-high reset
//   push        : write push_entry at the clock edge (ignored when full)
//   pop         : retire the head entry at the clock edge (ignored when empty)
//   head        : current oldest entry
//   full, empty : occupancy flags derived from the registered count
//   count       : number of valid entries (DEPTH_LOG2+1 bits)
// -----------------------------------------------------------------------------
module store_fifo
    import data_store_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                push,
    input  store_entry_t        push_entry,
    input  logic                pop,
    output store_entry_t        head,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    store_entry_t            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; count alone defines which entries
    // are valid, so clearing the data would only cost flops.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally at 2^DEPTH_LOG2.
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;  // idle, or push and pop together
            endcase
        end
    end

    assign full  = (count == CNT_DEPTH);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/data_store.sv
// -----------------------------------------------------------------------------
// data_store
//   AXI4 write initiator for the RV32I store path. Store requests are buffered
//   in order and drained one single-beat write at a time.
//   CLK, RST          : clock, asynchronous active-high reset
//   WREN/ADDR/DIN/BE  : store request, taken when MEM_WAIT=0
//   MEM_WAIT          : buffer full, upstream holds its request
//   DRAINED           : no buffered or in-flight store
//   ERR               : sticky, set by any error write response
//   m_axi             : AXI4 AW/W/B master channels
// -----------------------------------------------------------------------------
module data_store
    import data_store_pkg::*;
#(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int C_M_AXI_WUSER_WIDTH     = 4,
    parameter int C_M_AXI_BUSER_WIDTH     = 1,
    parameter int C_DEPTH_LOG2            = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WREN,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       DIN,
    input  logic [3:0]        BE,
    output logic              MEM_WAIT,
    output logic              DRAINED,
    output logic              ERR,
    data_store_if.master      m_axi
);
    localparam int SINK_W = C_M_AXI_THREAD_ID_WIDTH + C_M_AXI_BUSER_WIDTH + 2;

    state_t                  state_q;
    state_t                  state_d;
    store_entry_t            push_entry;
    store_entry_t            head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [C_DEPTH_LOG2:0]   fifo_count;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic                    err_q;
    logic [31:0]             awaddr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    aw_fin;
    logic                    w_fin;

    // Response ID/USER and the byte offset carry no information for this path.
    logic [SINK_W-1:0]       unused_in;
    assign unused_in = {m_axi.M_AXI_BID, m_axi.M_AXI_BUSER, ADDR[1:0]};

    // ---------------- store buffer ----------------
    assign push_entry = '{word_addr: ADDR[31:2], be: BE, data: DIN};
    assign fifo_push  = WREN && !MEM_WAIT;
    // The head stays buffered until its write response arrives.
    assign fifo_pop   = (state_q == RESP) && b_hs;

    store_fifo #(.DEPTH_LOG2(C_DEPTH_LOG2)) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign MEM_WAIT = fifo_full;
    assign DRAINED  = (fifo_count == '0) && (state_q == IDLE);
    assign ERR      = err_q;

    // ---------------- handshakes ----------------
    assign aw_hs  = awvalid_q && m_axi.M_AXI_AWREADY;
    assign w_hs   = wvalid_q && m_axi.M_AXI_WREADY;
    assign b_hs   = bready_q && m_axi.M_AXI_BVALID;
    // A channel counts as finished if it completed earlier or completes now.
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: defaulting state_d before the case keeps every path assigned,
        // so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty)      state_d = SEND;
            SEND:    if (aw_fin && w_fin)  state_d = RESP;
            RESP:    if (b_hs)             state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // ---------------- FSM: registered outputs ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        awaddr_q  <= {head.word_addr, 2'b00};
                        wdata_q   <= head.data;
                        wstrb_q   <= head.be;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                SEND: begin
                    // AW and W retire independently; payloads hold until then.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) bready_q <= 1'b1;
                end
                RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (resp_is_error(m_axi.M_AXI_BRESP)) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- AXI outputs ----------------
    assign m_axi.M_AXI_AWID    = C_M_AXI_THREAD_ID_WIDTH'(0);
    assign m_axi.M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(awaddr_q);
    assign m_axi.M_AXI_AWLEN   = 8'd0;
    assign m_axi.M_AXI_AWSIZE  = SIZE_4B;
    assign m_axi.M_AXI_AWBURST = BURST_INCR;
    assign m_axi.M_AXI_AWLOCK  = 2'b00;
    assign m_axi.M_AXI_AWCACHE = CACHE_NORMAL;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWQOS   = 4'b0000;
    assign m_axi.M_AXI_AWUSER  = C_M_AXI_AWUSER_WIDTH'(0);
    assign m_axi.M_AXI_AWVALID = awvalid_q;

    assign m_axi.M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(wdata_q);
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WLAST   = 1'b1;
    assign m_axi.M_AXI_WUSER   = C_M_AXI_WUSER_WIDTH'(0);
    assign m_axi.M_AXI_WVALID  = wvalid_q;

    assign m_axi.M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_data_store.sv
// -----------------------------------------------------------------------------
// tb_data_store
//   Directed bench for data_store: a table of single stores with hand-computed
//   AXI fields, followed by hand-written multi-cycle sequences (split
//   handshake, buffer fill, error response, reset during a response).
// -----------------------------------------------------------------------------
module tb_data_store;
    import data_store_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WREN;
    logic [31:0] ADDR;
    logic [31:0] DIN;
    logic [3:0]  BE;
    logic        MEM_WAIT;
    logic        DRAINED;
    logic        ERR;

    data_store_if axi ();

    data_store dut (
        .CLK      (CLK),
        .RST      (RST),
        .WREN     (WREN),
        .ADDR     (ADDR),
        .DIN      (DIN),
        .BE       (BE),
        .MEM_WAIT (MEM_WAIT),
        .DRAINED  (DRAINED),
        .ERR      (ERR),
        .m_axi    (axi)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [31:0] exp_awaddr;
        logic [3:0]  exp_wstrb;
    } vec_t;

    localparam int NVEC = 5;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got [5];
    logic [31:0] fill_addr [5];
    logic [31:0] err_addr [3];
    int          n_aw;
    int          n_b;
    bit          done;
    bit          pend;
    bit          pushed5;
    bit          b_now;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One store with an always-ready slave; B is returned once BREADY is up.
    task automatic run_single(input vec_t v, input string tag, input logic exp_err);
        axi.M_AXI_AWREADY = 1'b1;
        axi.M_AXI_WREADY  = 1'b1;
        axi.M_AXI_BVALID  = 1'b0;
        axi.M_AXI_BRESP   = RESP_OKAY;
        check({tag, "_drained_before"}, DRAINED, 1'b1);
        WREN = 1'b1; ADDR = v.addr; DIN = v.din; BE = v.be;
        tick();                                   // push edge
        WREN = 1'b0;
        check({tag, "_awvalid_wait"}, axi.M_AXI_AWVALID, 1'b0);
        check({tag, "_drained_busy"}, DRAINED, 1'b0);
        tick();                                   // head loaded
        check({tag, "_awvalid"}, axi.M_AXI_AWVALID, 1'b1);
        check({tag, "_wvalid"},  axi.M_AXI_WVALID, 1'b1);
        check({tag, "_awaddr"},  axi.M_AXI_AWADDR, v.exp_awaddr);
        check({tag, "_wdata"},   axi.M_AXI_WDATA, v.din);
        check({tag, "_wstrb"},   axi.M_AXI_WSTRB, v.exp_wstrb);
        check({tag, "_wlast"},   axi.M_AXI_WLAST, 1'b1);
        check({tag, "_aw_const"},
              {axi.M_AXI_AWID, axi.M_AXI_AWLEN, axi.M_AXI_AWSIZE, axi.M_AXI_AWBURST,
               axi.M_AXI_AWLOCK, axi.M_AXI_AWCACHE, axi.M_AXI_AWPROT, axi.M_AXI_AWQOS},
              {1'b0, 8'h00, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0});
        check({tag, "_user"}, {axi.M_AXI_AWUSER, axi.M_AXI_WUSER}, 5'd0);
        check({tag, "_bready_early"}, axi.M_AXI_BREADY, 1'b0);
        tick();                                   // AW and W handshakes
        check({tag, "_aw_drop"}, axi.M_AXI_AWVALID, 1'b0);
        check({tag, "_w_drop"},  axi.M_AXI_WVALID, 1'b0);
        check({tag, "_bready"},  axi.M_AXI_BREADY, 1'b1);
        axi.M_AXI_BVALID = 1'b1;
        tick();                                   // B handshake
        axi.M_AXI_BVALID = 1'b0;
        check({tag, "_bready_drop"}, axi.M_AXI_BREADY, 1'b0);
        check({tag, "_drained_after"}, DRAINED, 1'b1);
        check({tag, "_err"}, ERR, exp_err);
    endtask

    initial begin
        vecs[0] = '{32'h2000_0104, 32'hDEAD_BEEF, 4'hF,    32'h2000_0104, 4'hF};
        vecs[1] = '{32'h2000_0102, 32'h00AB_0000, 4'b0100, 32'h2000_0100, 4'b0100};
        vecs[2] = '{32'h1000_0003, 32'h1234_5678, 4'b1000, 32'h1000_0000, 4'b1000};
        vecs[3] = '{32'h2000_0200, 32'h1122_3344, 4'b0000, 32'h2000_0200, 4'b0000};
        vecs[4] = '{32'hFFFF_FFFE, 32'hA5A5_A5A5, 4'b0011, 32'hFFFF_FFFC, 4'b0011};

        fill_addr[0] = 32'h4000_0000; fill_addr[1] = 32'h4000_0010;
        fill_addr[2] = 32'h4000_0020; fill_addr[3] = 32'h4000_0030;
        fill_addr[4] = 32'h4000_0040;
        err_addr[0]  = 32'h5000_0000; err_addr[1] = 32'h5000_0004;
        err_addr[2]  = 32'h5000_0008;

        RST = 1'b0; WREN = 1'b0; ADDR = '0; DIN = '0; BE = '0;
        axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
        axi.M_AXI_BVALID  = 1'b0; axi.M_AXI_BRESP  = RESP_OKAY;
        axi.M_AXI_BID     = '0;   axi.M_AXI_BUSER  = '0;

        // ---------------- reset values ----------------
        #2 RST = 1'b1;
        #1;
        check("rst_awvalid",  axi.M_AXI_AWVALID, 1'b0);
        check("rst_wvalid",   axi.M_AXI_WVALID, 1'b0);
        check("rst_bready",   axi.M_AXI_BREADY, 1'b0);
        check("rst_err",      ERR, 1'b0);
        check("rst_mem_wait", MEM_WAIT, 1'b0);
        check("rst_drained",  DRAINED, 1'b1);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // ---------------- table of single stores ----------------
        for (int i = 0; i < NVEC; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // ---------------- split handshake ----------------
        axi.M_AXI_AWREADY = 1'b1;
        axi.M_AXI_WREADY  = 1'b0;
        WREN = 1'b1; ADDR = 32'h3000_0008; DIN = 32'hCAFE_F00D; BE = 4'hF;
        tick();
        WREN = 1'b0;
        tick();                                   // head loaded
        for (int c = 0; c < 4; c++) begin
            if (c == 3) axi.M_AXI_WREADY = 1'b1;
            check($sformatf("split_wvalid_c%0d", c),  axi.M_AXI_WVALID, 1'b1);
            check($sformatf("split_wdata_c%0d", c),   axi.M_AXI_WDATA, 32'hCAFE_F00D);
            check($sformatf("split_awvalid_c%0d", c), axi.M_AXI_AWVALID, (c == 0));
            check($sformatf("split_bready_c%0d", c),  axi.M_AXI_BREADY, 1'b0);
            tick();
        end
        axi.M_AXI_WREADY = 1'b0;
        check("split_wvalid_drop", axi.M_AXI_WVALID, 1'b0);
        check("split_bready", axi.M_AXI_BREADY, 1'b1);
        axi.M_AXI_BVALID = 1'b1;
        tick();
        check("split_bready_drop", axi.M_AXI_BREADY, 1'b0);
        check("split_drained", DRAINED, 1'b1);
        tick();                                   // BVALID still high: must be ignored
        axi.M_AXI_BVALID = 1'b0;
        check("split_single_b_bready", axi.M_AXI_BREADY, 1'b0);
        check("split_single_b_awvalid", axi.M_AXI_AWVALID, 1'b0);
        check("split_single_b_drained", DRAINED, 1'b1);

        // ---------------- buffer fill ----------------
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_mem_wait_pre%0d", i), MEM_WAIT, 1'b0);
            WREN = 1'b1; ADDR = fill_addr[i]; DIN = 32'h100 + i; BE = 4'hF;
            tick();
        end
        WREN = 1'b1; ADDR = fill_addr[4]; DIN = 32'h104; BE = 4'hF;
        check("fill_mem_wait_full", MEM_WAIT, 1'b1);
        tick();
        tick();
        check("fill_mem_wait_hold", MEM_WAIT, 1'b1);
        check("fill_aw_head", axi.M_AXI_AWADDR, fill_addr[0]);
        check("fill_aw_pending", axi.M_AXI_AWVALID, 1'b1);
        axi.M_AXI_AWREADY = 1'b1;
        n_aw = 0; done = 1'b0; pend = 1'b0; pushed5 = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (n_aw == 5 && DRAINED && !WREN) begin
                done = 1'b1;
                break;
            end
            if (WREN && !MEM_WAIT) pend = 1'b1;
            if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY && n_aw < 5) begin
                got[n_aw] = axi.M_AXI_AWADDR;
                n_aw++;
            end
            axi.M_AXI_BVALID = axi.M_AXI_BREADY;
            tick();
            if (pend) begin
                WREN = 1'b0; pend = 1'b0; pushed5 = 1'b1;
            end
        end
        axi.M_AXI_BVALID = 1'b0;
        check("fill_done", done, 1'b1);
        check("fill_fifth_pushed", pushed5, 1'b1);
        check("fill_aw_count", n_aw, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_order%0d", i), got[i], fill_addr[i]);
        end

        // ---------------- error response on the 2nd of 3 ----------------
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WREN = 1'b1; ADDR = err_addr[i]; DIN = 32'h200 + i; BE = 4'hF;
            tick();
        end
        WREN = 1'b0;
        axi.M_AXI_AWREADY = 1'b1;
        n_aw = 0; n_b = 0; done = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (n_b == 3 && DRAINED) begin
                done = 1'b1;
                break;
            end
            if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY && n_aw < 3) begin
                got[n_aw] = axi.M_AXI_AWADDR;
                n_aw++;
            end
            b_now = axi.M_AXI_BREADY;
            axi.M_AXI_BVALID = axi.M_AXI_BREADY;
            axi.M_AXI_BRESP  = (n_b == 1) ? RESP_SLVERR : RESP_OKAY;
            tick();
            if (b_now) begin
                n_b++;
                check($sformatf("err_after_b%0d", n_b), ERR, (n_b >= 2));
            end
        end
        axi.M_AXI_BVALID = 1'b0;
        axi.M_AXI_BRESP  = RESP_OKAY;
        check("err_done", done, 1'b1);
        check("err_aw_count", n_aw, 3);
        check("err_third_issued", got[2], err_addr[2]);
        tick();
        tick();
        check("err_sticky", ERR, 1'b1);
        run_single(vecs[1], "err_clean", 1'b1);

        // ---------------- asynchronous reset while in RESP ----------------
        axi.M_AXI_AWREADY = 1'b1;
        axi.M_AXI_WREADY  = 1'b1;
        WREN = 1'b1; ADDR = 32'h6000_0010; DIN = 32'h0BAD_F00D; BE = 4'hF;
        tick();
        WREN = 1'b0;
        tick();
        tick();
        check("arst_in_resp", axi.M_AXI_BREADY, 1'b1);
        #2 RST = 1'b1;
        #1;                                       // still before the next edge
        check("arst_awvalid", axi.M_AXI_AWVALID, 1'b0);
        check("arst_wvalid",  axi.M_AXI_WVALID, 1'b0);
        check("arst_bready",  axi.M_AXI_BREADY, 1'b0);
        check("arst_drained", DRAINED, 1'b1);
        check("arst_err",     ERR, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        run_single(vecs[0], "post_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
